// File: rtl/arm_pipelined_elastic_register.sv
// Elastic two-entry pipeline register (main + skid) with valid/ready and flush.
// Optional stall counter enabled by ARM_PIPE_ELASTIC_STALL_CNT_EN.
module arm_pipelined_elastic_register #(
   parameter int unsigned         BusWidth   = 32,
   parameter logic [BusWidth-1:0] ResetValue = '0,
   parameter int unsigned         CntWidth   = 32
) (
   input  logic                i_CLK,
   input  logic                i_NRESET,
   input  logic                i_FLUSH,
   input  logic                i_Valid,
   output logic                o_Ready,
   input  logic [BusWidth-1:0] i_In,
   output logic                o_Valid,
   input  logic                i_Ready,
   output logic [BusWidth-1:0] o_Out
`ifdef ARM_PIPE_ELASTIC_STALL_CNT_EN
   ,
   output logic [CntWidth-1:0] o_StallCount
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_ONE,
      S_FULL
   } state_t;

   state_t              r_State;
   state_t              w_NextState;
   logic [BusWidth-1:0] r_Main;
   logic [BusWidth-1:0] r_Skid;
   logic                w_InFire;
   logic                w_OutFire;
   logic                w_LoadMainIn;
   logic                w_LoadMainSkid;
   logic                w_LoadSkid;

   if (CntWidth == 0 || BusWidth == 0) begin : g_bad_width
      $error("BusWidth and CntWidth must be non-zero");
   end

   // Ready looks only at the skid slot, never at i_Ready.
   assign o_Ready   = i_NRESET & ~i_FLUSH & (r_State != S_FULL);
   assign o_Valid   = (r_State != S_EMPTY);
   assign o_Out     = r_Main;
   assign w_InFire  = i_Valid & o_Ready;
   assign w_OutFire = o_Valid & i_Ready;

   always_comb begin
      w_NextState    = r_State;
      w_LoadMainIn   = 1'b0;
      w_LoadMainSkid = 1'b0;
      w_LoadSkid     = 1'b0;
      unique case (r_State)
         S_EMPTY: begin
            if (w_InFire) begin
               w_NextState  = S_ONE;
               w_LoadMainIn = 1'b1;
            end
         end
         S_ONE: begin
            if (w_InFire && w_OutFire) begin
               w_LoadMainIn = 1'b1;
            end else if (w_InFire) begin
               w_NextState = S_FULL;
               w_LoadSkid  = 1'b1;
            end else if (w_OutFire) begin
               w_NextState = S_EMPTY;
            end
         end
         S_FULL: begin
            if (w_OutFire) begin
               w_NextState    = S_ONE;
               w_LoadMainSkid = 1'b1;
            end
         end
         default: w_NextState = S_EMPTY;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (!i_NRESET || i_FLUSH) begin
         r_State <= S_EMPTY;
         r_Main  <= ResetValue;
         r_Skid  <= ResetValue;
      end else begin
         r_State <= w_NextState;
         if (w_LoadMainIn) begin
            r_Main <= i_In;
         end else if (w_LoadMainSkid) begin
            r_Main <= r_Skid;
         end
         if (w_LoadSkid) begin
            r_Skid <= i_In;
         end
      end
   end

`ifdef ARM_PIPE_ELASTIC_STALL_CNT_EN
   localparam logic [CntWidth-1:0] CntOne = 1;
   localparam logic [CntWidth-1:0] CntMax = '1;

   logic [CntWidth-1:0] r_StallCount;

   // Saturating; survives flush, cleared only by reset.
   always_ff @(posedge i_CLK) begin
      if (!i_NRESET) begin
         r_StallCount <= '0;
      end else if (o_Valid && !i_Ready && (r_StallCount != CntMax)) begin
         r_StallCount <= r_StallCount + CntOne;
      end
   end

   assign o_StallCount = r_StallCount;
`endif

endmodule

// File: tb/tb_arm_pipelined_elastic_register.sv
// Scoreboard bench for arm_pipelined_elastic_register: directed vectors,
// expected payloads queued at in_fire and checked by a separate monitor.
module tb_arm_pipelined_elastic_register;

   logic        i_CLK = 1'b0;
   logic        i_NRESET;
   logic        i_FLUSH;
   logic        i_Valid;
   logic        o_Ready;
   logic [31:0] i_In;
   logic        o_Valid;
   logic        i_Ready;
   logic [31:0] o_Out;
`ifdef ARM_PIPE_ELASTIC_STALL_CNT_EN
   logic [2:0]  o_StallCount;
`endif

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb_q[$];

   arm_pipelined_elastic_register #(
      .BusWidth   (32),
      .ResetValue (32'h0),
      .CntWidth   (3)
   ) dut (
      .i_CLK        (i_CLK),
      .i_NRESET     (i_NRESET),
      .i_FLUSH      (i_FLUSH),
      .i_Valid      (i_Valid),
      .o_Ready      (o_Ready),
      .i_In         (i_In),
      .o_Valid      (o_Valid),
      .i_Ready      (i_Ready),
      .o_Out        (o_Out)
`ifdef ARM_PIPE_ELASTIC_STALL_CNT_EN
      ,
      .o_StallCount (o_StallCount)
`endif
   );

   always #5 i_CLK = ~i_CLK;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every out_fire pops the oldest expected payload.
   always @(negedge i_CLK) begin
      if (i_NRESET && !i_FLUSH && o_Valid && i_Ready) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got %h expected nothing", o_Out);
         end else begin
            check("sb_data", o_Out, sb_q.pop_front());
         end
      end
   end

   // Present one payload, wait (bounded) for acceptance.
   task automatic send(input logic [31:0] d);
      bit done = 0;
      i_Valid = 1'b1;
      i_In    = d;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge i_CLK);
         if (o_Ready) begin
            sb_q.push_back(d);
            done = 1;
         end
         @(posedge i_CLK);
         #1;
      end
      i_Valid = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no ready expected ready for %h", d);
      end
   endtask

   initial begin
      i_NRESET = 1'b0;
      i_FLUSH  = 1'b0;
      i_Valid  = 1'b1;
      i_In     = 32'hDEADBEEF;
      i_Ready  = 1'b0;

      // Reset with a payload offered
      repeat (2) @(posedge i_CLK);
      @(negedge i_CLK);
      check("rst_valid", {31'b0, o_Valid}, 32'd0);
      check("rst_out", o_Out, 32'h0);
      check("rst_ready", {31'b0, o_Ready}, 32'd0);
`ifdef ARM_PIPE_ELASTIC_STALL_CNT_EN
      check("rst_cnt", {29'b0, o_StallCount}, 32'd0);
`endif
      @(posedge i_CLK);
      #1;
      i_NRESET = 1'b1;
      i_Valid  = 1'b0;
      @(negedge i_CLK);
      check("rel_ready", {31'b0, o_Ready}, 32'd1);
      check("rel_valid", {31'b0, o_Valid}, 32'd0);
      @(posedge i_CLK);
      #1;

      // Streaming at full throughput
      i_Ready = 1'b1;
      for (int d = 1; d <= 4; d++) begin
         i_Valid = 1'b1;
         i_In    = d;
         @(negedge i_CLK);
         check("stream_ready", {31'b0, o_Ready}, 32'd1);
         if (d > 1) begin
            check("stream_valid", {31'b0, o_Valid}, 32'd1);
            check("stream_out", o_Out, d - 1);
         end
         sb_q.push_back(d);
         @(posedge i_CLK);
         #1;
      end
      i_Valid = 1'b0;
      @(negedge i_CLK);
      check("stream_last", o_Out, 32'd4);
      @(posedge i_CLK);
      #1;
      @(negedge i_CLK);
      check("stream_drain", {31'b0, o_Valid}, 32'd0);
      @(posedge i_CLK);
      #1;

      // Back-pressure into the skid slot
      i_Ready = 1'b0;
      send(32'hA);
      send(32'hB);
      for (int k = 0; k < 3; k++) begin
         @(negedge i_CLK);
         check("bp_ready", {31'b0, o_Ready}, 32'd0);
         check("bp_valid", {31'b0, o_Valid}, 32'd1);
         check("bp_hold", o_Out, 32'hA);
         @(posedge i_CLK);
         #1;
      end
      i_Ready = 1'b1;
      repeat (2) @(posedge i_CLK);
      #1;
      @(negedge i_CLK);
      check("bp_drain", {31'b0, o_Valid}, 32'd0);
      @(posedge i_CLK);
      #1;

      // Flush while FULL, with a stall long enough to saturate
      i_Ready = 1'b0;
      send(32'hA);
      send(32'hB);
      repeat (10) @(posedge i_CLK);
      #1;
`ifdef ARM_PIPE_ELASTIC_STALL_CNT_EN
      check("cnt_sat", {29'b0, o_StallCount}, 32'd7);
`endif
      i_FLUSH = 1'b1;
      i_Valid = 1'b1;
      i_In    = 32'hC;
      sb_q.delete();
      @(negedge i_CLK);
      check("flush_ready", {31'b0, o_Ready}, 32'd0);
      @(posedge i_CLK);
      #1;
      i_FLUSH = 1'b0;
      i_Valid = 1'b0;
      @(negedge i_CLK);
      check("flush_valid", {31'b0, o_Valid}, 32'd0);
      check("flush_out", o_Out, 32'h0);
      check("flush_ready_after", {31'b0, o_Ready}, 32'd1);
`ifdef ARM_PIPE_ELASTIC_STALL_CNT_EN
      check("flush_cnt", {29'b0, o_StallCount}, 32'd7);
`endif
      @(posedge i_CLK);
      #1;
      @(negedge i_CLK);
      check("flush_no_c", {31'b0, o_Valid}, 32'd0);
      @(posedge i_CLK);
      #1;

      // Simultaneous in/out while ONE
      send(32'h5);
      i_Ready = 1'b1;
      send(32'h6);
      @(negedge i_CLK);
      check("sim_valid", {31'b0, o_Valid}, 32'd1);
      check("sim_out", o_Out, 32'h6);
      check("sim_noskid", {31'b0, o_Ready}, 32'd1);
      @(posedge i_CLK);
      #1;
      @(negedge i_CLK);
      check("sim_drain", {31'b0, o_Valid}, 32'd0);
      @(posedge i_CLK);
      #1;

      // Reset while FULL
      i_Ready = 1'b0;
      send(32'h11);
      send(32'h22);
      i_NRESET = 1'b0;
      sb_q.delete();
      @(posedge i_CLK);
      #1;
      i_NRESET = 1'b1;
      @(negedge i_CLK);
      check("mrst_valid", {31'b0, o_Valid}, 32'd0);
      check("mrst_out", o_Out, 32'h0);
      check("mrst_ready", {31'b0, o_Ready}, 32'd1);
`ifdef ARM_PIPE_ELASTIC_STALL_CNT_EN
      check("mrst_cnt", {29'b0, o_StallCount}, 32'd0);
`endif
      @(posedge i_CLK);
      #1;

      // Recovery after reset
      i_Ready = 1'b1;
      send(32'h33);
      repeat (3) @(posedge i_CLK);
      #1;
      check("sb_empty", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
